// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared sizes, glyph attribute and FSM state type for the display line writer
package disp_pkg;
    localparam int         SLOT_W     = 16;
    localparam int         NUM_SLOTS  = 32;
    localparam int         LINE_W     = 513;
    localparam logic [7:0] GLYPH_ATTR = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_FIN
    } disp_state_e;
endpackage

// File: rtl/disp_slot_sel.sv
// rtl/disp_slot_sel.sv - combinational pick of one character slot out of a packed glyph line
module disp_slot_sel #(
    parameter int NUM_SLOTS = disp_pkg::NUM_SLOTS,
    parameter int SLOT_W    = disp_pkg::SLOT_W,
    parameter int IDX_W     = $clog2(NUM_SLOTS) + 1
) (
    input  logic [disp_pkg::LINE_W-1:0] line_in,
    input  logic [IDX_W-1:0]            idx,
    output logic [SLOT_W-1:0]           slot
);
    import disp_pkg::*;

    // Bits above the last slot carry nothing.
    logic unused_tail;
    assign unused_tail = ^line_in[LINE_W-1:NUM_SLOTS*SLOT_W];

    always_comb begin
        slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx == IDX_W'(i)) begin
                slot = line_in[i*SLOT_W +: SLOT_W];
            end
        end
    end
endmodule

// File: rtl/disp_line_writer.sv
// rtl/disp_line_writer.sv - streams a snapshotted glyph line into display RAM, one slot per beat
// Optional: DISP_SKIP_BLANK_EN suppresses beats for all-zero slots.
module disp_line_writer #(
    parameter int NUM_SLOTS = disp_pkg::NUM_SLOTS,
    parameter int SLOT_W    = disp_pkg::SLOT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [disp_pkg::LINE_W-1:0] line_data,
    input  logic [7:0]                  base_addr,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [7:0]                  wr_addr,
    output logic [SLOT_W-1:0]           wr_data,
    output logic                        busy,
    output logic                        done
);
    import disp_pkg::*;

    localparam int IDX_W = $clog2(NUM_SLOTS) + 1;

    disp_state_e       state_q, state_d;
    logic [LINE_W-1:0] snap_q, snap_d;
    logic [7:0]        base_q, base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_valid_q, wr_valid_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [SLOT_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [LINE_W-1:0] search_src;
    logic [IDX_W-1:0]  search_from;
    logic [IDX_W-1:0]  nxt_idx;
    logic              found;
    logic [SLOT_W-1:0] sel_data;

    // In IDLE the first beat is built straight from the inputs so it can appear the cycle after start.
    assign search_src  = (state_q == ST_IDLE) ? line_data : snap_q;
    assign search_from = (state_q == ST_IDLE) ? '0 : idx_q + 1'b1;

    always_comb begin
        found   = 1'b0;
        nxt_idx = '0;
`ifdef DISP_SKIP_BLANK_EN
        for (int j = NUM_SLOTS - 1; j >= 0; j--) begin
            if ((IDX_W'(j) >= search_from) && (search_src[j*SLOT_W +: SLOT_W] != '0)) begin
                found   = 1'b1;
                nxt_idx = IDX_W'(j);
            end
        end
`else
        found   = (search_from < IDX_W'(NUM_SLOTS));
        nxt_idx = search_from;
`endif
    end

    disp_slot_sel #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W),
        .IDX_W     (IDX_W)
    ) u_slot_sel (
        .line_in (search_src),
        .idx     (nxt_idx),
        .slot    (sel_data)
    );

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        base_d     = base_q;
        idx_d      = idx_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d = line_data;
                    base_d = base_addr;
                    if (found) begin
                        state_d    = ST_SEND;
                        idx_d      = nxt_idx;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = base_addr + 8'(nxt_idx);
                        wr_data_d  = sel_data;
                        busy_d     = 1'b1;
                    end else begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (wr_ready) begin
                    if (found) begin
                        idx_d     = nxt_idx;
                        wr_addr_d = base_q + 8'(nxt_idx);
                        wr_data_d = sel_data;
                    end else begin
                        state_d    = ST_FIN;
                        wr_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            base_q     <= '0;
            idx_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_disp_line_writer.sv
// tb/tb_disp_line_writer.sv - directed self-checking bench for disp_line_writer
module tb_disp_line_writer;
    localparam int NS = 32;
`ifdef DISP_SKIP_BLANK_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start     = 1'b0;
    logic         wr_ready  = 1'b1;
    logic [512:0] line_data = '0;
    logic [7:0]   base_addr = 8'h00;
    logic         wr_valid;
    logic [7:0]   wr_addr;
    logic [15:0]  wr_data;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    disp_line_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .line_data (line_data),
        .base_addr (base_addr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] slot_of(input logic [512:0] ln, input int s);
        return ln[s*16 +: 16];
    endfunction

    function automatic int next_slot(input logic [512:0] ln, input int s);
        int k = s;
        while (SKIP_EN && k < NS && slot_of(ln, k) == 16'h0000) k++;
        return k;
    endfunction

    function automatic logic [512:0] make_line(input logic top_bit);
        logic [512:0] ln;
        ln      = '0;
        ln[512] = top_bit;
        for (int i = 0; i < NS; i++) ln[i*16 +: 16] = {8'hFF, 8'(8'h41 + i)};
        ln[15:0]  = 16'hFF50;
        ln[31:16] = 16'hFF43;
        ln[47:32] = 16'hFF3A;
        return ln;
    endfunction

    task automatic kick(input logic [512:0] ln, input logic [7:0] ba);
        line_data = ln;
        base_addr = ba;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input string tag, input logic [512:0] ln, input logic [7:0] ba,
                          input int stall_at, input int stall_n, input bit disturb,
                          input int abort_at, output int cyc);
        int s;
        int left;
        s    = next_slot(ln, 0);
        left = stall_n;
        cyc  = 0;
        while (s < NS) begin
            if (cyc >= 200) begin
                check({tag, " timeout"}, cyc, 0);
                break;
            end
            if (s == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                check({tag, " abort valid"}, wr_valid, 0);
                check({tag, " abort busy"}, busy, 0);
                check({tag, " abort done"}, done, 0);
                return;
            end
            check({tag, " valid"}, wr_valid, 1);
            check({tag, " addr"}, wr_addr, 8'(ba + s));
            check({tag, " data"}, wr_data, slot_of(ln, s));
            check({tag, " busy"}, busy, 1);
            check({tag, " done early"}, done, 0);
            if (s == stall_at && left > 0) begin
                wr_ready = 1'b0;
                left--;
            end else begin
                wr_ready = 1'b1;
            end
            if (disturb && s == 4) begin
                start     = 1'b1;
                line_data = ~ln;
                base_addr = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            if (wr_ready) s = next_slot(ln, s + 1);
            @(negedge clk);
            cyc++;
        end
        wr_ready = 1'b1;
        start    = 1'b0;
        check({tag, " done pulse"}, done, 1);
        check({tag, " valid after"}, wr_valid, 0);
        check({tag, " busy after"}, busy, 0);
        @(negedge clk);
        check({tag, " done single"}, done, 0);
        check({tag, " idle valid"}, wr_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [512:0] l1;
        logic [512:0] l2;
        logic [512:0] l3;

        l1 = make_line(1'b1);
        l2 = make_line(1'b0);
        l2[63:48] = 16'hFF7E;
        l3 = l1;
        l3[11*16 +: 16] = 16'h0000;
        for (int i = 24; i < NS; i++) l3[i*16 +: 16] = 16'h0000;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset wr_valid", wr_valid, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset wr_data", wr_data, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle wr_valid", wr_valid, 0);

        kick(l1, 8'd68);
        stream("basic", l1, 8'd68, -1, 0, 1'b0, -1, cyc);
        check("basic cycles", cyc, 32);

        kick(l1, 8'd68);
        stream("stall", l1, 8'd68, 5, 3, 1'b0, -1, cyc);
        check("stall cycles", cyc, 35);

        kick(l2, 8'hF0);
        stream("wrap", l2, 8'hF0, -1, 0, 1'b0, -1, cyc);
        check("wrap cycles", cyc, 32);

        kick(l1, 8'd68);
        stream("restart", l1, 8'd68, -1, 0, 1'b1, -1, cyc);
        check("restart cycles", cyc, 32);
        for (int i = 0; i < 4; i++) begin
            check("restart no second done", done, 0);
            check("restart no second line", wr_valid, 0);
            @(negedge clk);
        end

        kick(l1, 8'd68);
        stream("abort", l1, 8'd68, -1, 0, 1'b0, 10, cyc);
        check("abort beats", cyc, 10);
        for (int i = 0; i < 3; i++) begin
            check("abort no done", done, 0);
            check("abort stays idle", wr_valid, 0);
            @(negedge clk);
        end
        kick(l2, 8'd20);
        stream("fresh", l2, 8'd20, -1, 0, 1'b0, -1, cyc);
        check("fresh cycles", cyc, 32);

        kick(l3, 8'd68);
        stream("blank", l3, 8'd68, -1, 0, 1'b0, -1, cyc);
        check("blank beats", cyc, SKIP_EN ? 23 : 32);

`ifdef DISP_SKIP_BLANK_EN
        kick('0, 8'd5);
        check("all zero done", done, 1);
        check("all zero valid", wr_valid, 0);
        check("all zero busy", busy, 0);
        @(negedge clk);
        check("all zero done single", done, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/disp_line_writer.md
DISP_LINE_WRITER -- requirements
Module: disp_line_writer

Interface
REQ-001 The block SHALL have a parameter NUM_SLOTS, default 32, giving the number of 16-bit character slots per line.
REQ-002 The block SHALL have a parameter SLOT_W, default 16, giving the width of one character slot (attribute byte [15:8], ASCII byte [7:0]).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  one-cycle request to stream a line; sampled only in IDLE.
REQ-007 line_data  input  513  packed glyph line; slot i = bits [16i+15:16i]; bit 512 ignored.
REQ-008 base_addr  input  8  display RAM address of slot 0.
REQ-009 wr_valid  output  1  write beat valid.
REQ-010 wr_ready  input  1  display RAM accepts the beat.
REQ-011 wr_addr  output  8  display RAM write address.
REQ-012 wr_data  output  16  glyph code for wr_addr.
REQ-013 busy  output  1  high while a line is being streamed.
REQ-014 done  output  1  one-cycle pulse after the last beat of a line.

Function
REQ-015 FSM states: IDLE, SEND, FIN; IDLE->SEND on start=1; SEND->FIN on handshake of the last slot; FIN->IDLE unconditionally after one cycle.
REQ-016 On start in IDLE, line_data and base_addr SHALL be snapshotted; later input changes SHALL not affect the line in progress.
REQ-017 wr_valid SHALL rise in the cycle after start is sampled, carrying slot 0 at address base_addr.
REQ-018 A handshake occurs when wr_valid and wr_ready are both high at a rising edge; only then SHALL the slot index advance.
REQ-019 While wr_valid=1 and wr_ready=0, wr_addr and wr_data SHALL hold stable.
REQ-020 wr_addr SHALL equal (base_addr + slot index) mod 256; wrap past 0xFF to 0x00 is legal.
REQ-021 With wr_ready held at 1, all NUM_SLOTS beats SHALL occupy consecutive cycles: throughput is one beat per cycle, with no bubbles.
REQ-022 busy SHALL be high from the cycle after start through the cycle of the last handshake; done SHALL be high only in FIN.
REQ-023 start asserted while busy or in FIN SHALL be ignored, and no queueing SHALL occur.
REQ-024 Slot order SHALL be ascending from 0 to NUM_SLOTS-1.

Reset
REQ-025 While rst_n=0 at a rising edge, the state SHALL become IDLE, the slot index 0, and the snapshot register 0.
REQ-026 Reset values of outputs: wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0.
REQ-027 Reset during SEND SHALL abort the line at the next edge without issuing done; a partially written line is acceptable.

Configuration
REQ-028 Macro DISP_SKIP_BLANK_EN:
- When defined, slots whose 16-bit value is 0x0000 SHALL be skipped. No beat is issued for them, but the address still advances by the slot index.
- When defined, if every slot is zero, the block SHALL go IDLE->FIN->IDLE with no beats.
- Skipping SHALL cost no extra cycles: the next beat is the next non-zero slot in the following cycle.
REQ-029 Without DISP_SKIP_BLANK_EN, every slot SHALL be written, including zero slots.

Structure
REQ-030 Shared package disp_pkg SHALL hold SLOT_W, NUM_SLOTS, LINE_W=513, the FSM state typedef, and the glyph attribute constant GLYPH_ATTR=8'hFF.
REQ-031 One sub-module, disp_slot_sel, SHALL select slot[index] from the snapshot; it is combinational and instantiated once.

Verification
REQ-032 Slots 0..2 = 0xFF50, 0xFF43, 0xFF3A, others nonzero; base_addr=68; wr_ready=1; start pulse -> beats at addresses 68..99 on 32 consecutive cycles, first beat data 0xFF50, then done a single cycle later.
REQ-033 wr_ready low for 3 cycles during slot 5 -> wr_addr=73 and wr_data held for 4 cycles; total line takes 35 cycles; no duplicate or missing address.
REQ-034 base_addr=0xF0 -> addresses 0xF0..0xFF then 0x00..0x0F, with no error.
REQ-035 Second start pulse mid-line, with line_data changed after start -> no restart; all data from the original snapshot; exactly one done.
REQ-036 rst_n=0 for 1 cycle at slot 10 -> wr_valid=0 and busy=0 the next cycle; done never pulses; a fresh start then begins at slot 0.
REQ-037 DISP_SKIP_BLANK_EN defined, slots 11 and 24..31 zero -> 23 beats, addresses 79 and 92..99 absent; done follows slot 23's handshake.
